// File: rtl/jk_excite_drv.sv
// jk_excite_drv: drives J/K excitation for a JK register bank, stepping Q toward a latched target
// in direct set/clear, toggle, or increment-until-equal (count) mode.
module jk_excite_drv #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         En,
    input  logic         tgt_valid,
    input  logic [W-1:0] tgt,
    input  logic [1:0]   mode,
    output logic         tgt_ready,
    output logic [W-1:0] J,
    output logic [W-1:0] K,
    output logic [W-1:0] Q,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] q_q, q_d, tgt_q, tgt_d, m;
    logic [1:0]   mode_q, mode_d;
    // Bits up to and including the lowest zero flip on increment: the ripple-carry toggle mask.
    assign m = q_q ^ (q_q + W'(1));
    assign Q = q_q;
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        mode_d    = mode_q;
        J         = '0;
        K         = '0;
        tgt_ready = (state_q == IDLE) && !reset;
        done      = (state_q == FIN);
        case (state_q)
            IDLE: if (tgt_valid && tgt_ready) begin
                tgt_d   = tgt;
                mode_d  = mode;
                state_d = DRIVE;
            end
            DRIVE: if (En) begin
                if (mode_q == 2'b10) begin
                    state_d = (q_q == tgt_q) ? FIN : DRIVE;
                    J       = (q_q == tgt_q) ? '0 : m;
                    K       = (q_q == tgt_q) ? '0 : m;
                end else begin
                    state_d = FIN;
                    J       = (mode_q == 2'b01) ? q_q ^ tgt_q : tgt_q & ~q_q;
                    K       = (mode_q == 2'b01) ? q_q ^ tgt_q : ~tgt_q & q_q;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        q_d = (J & ~q_q) | (~K & q_q);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            tgt_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
        end
    end
endmodule

// File: tb/tb_jk_excite_drv.sv
// tb_jk_excite_drv: randomized scoreboard bench; the driver predicts final value and latency per
// target, the monitor steps a value-level model of Q and checks J/K/Q/done/ready every cycle.
module tb_jk_excite_drv;
    logic       clk = 0, reset = 1, En = 0, tgt_valid = 0;
    logic [3:0] tgt = 0, J, K, Q;
    logic [1:0] mode = 0;
    logic       tgt_ready, done;
    int         checks = 0, errors = 0;
    typedef struct {
        logic [3:0] t;
        logic [1:0] m;
        int         lat;
    } txn_t;
    txn_t       sb[$];
    logic [3:0] cur_q = 0;

    jk_excite_drv #(.W(4)) dut (
        .clk(clk), .reset(reset), .En(En), .tgt_valid(tgt_valid), .tgt(tgt), .mode(mode),
        .tgt_ready(tgt_ready), .J(J), .K(K), .Q(Q), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // Called at a negedge with tgt_ready high; returns at the negedge where ready is high again.
    task automatic send(input logic [3:0] t, input logic [1:0] m, input bit rnd_en,
                        input int stall_at, input int abort_at);
        int  i = 0;
        bit  fin = 0;
        txn_t x;
        x.t = t; x.m = m;
        x.lat = (m == 2'b10) ? (((int'(t) - int'(cur_q)) & 15) + 1) : 1;
        sb.push_back(x);
        tgt_valid = 1; tgt = t; mode = m; En = 1;
        while (!fin && i < 200) begin
            @(negedge clk);
            if (tgt_ready) begin
                fin = 1;
            end else begin
                tgt_valid = 1'($urandom_range(0, 1));
                tgt = 4'($urandom);
                mode = 2'($urandom);
                En = rnd_en ? ($urandom_range(0, 3) != 0) : !(i == stall_at || i == stall_at + 1);
                if (i == abort_at) begin
                    reset = 1;
                    tgt_valid = 0;
                    repeat (2) @(negedge clk);
                    reset = 0;
                    cur_q = 0;
                    return;
                end
                i++;
            end
        end
        tgt_valid = 0;
        chk("drain_in_time", i < 200, 1);
        cur_q = t;
    endtask

    int         phase = 0, cnt = 0;
    logic [3:0] eq = 0, et = 0, ej, ek;
    logic [1:0] em = 0;
    logic       v, rdy, en, fin_now;
    initial begin
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                chk("rst_q", Q, 0);
                chk("rst_jk", {J, K}, 0);
                chk("rst_ready", tgt_ready, 0);
                chk("rst_done", done, 0);
                phase = 0; eq = 0; sb.delete();
                @(posedge clk);
                continue;
            end
            v = tgt_valid; rdy = tgt_ready; en = En;
            chk("ready", rdy, phase == 0);
            chk("q", Q, eq);
            ej = 0; ek = 0;
            if (phase == 1 && en) begin
                if (em == 2'b10) begin
                    ej = (eq == et) ? 4'd0 : eq ^ (eq + 4'd1);
                    ek = ej;
                end else if (em == 2'b01) begin
                    ej = eq ^ et; ek = ej;
                end else begin
                    ej = et & ~eq; ek = ~et & eq;
                end
            end
            chk("J", J, ej);
            chk("K", K, ek);
            @(posedge clk); #1;
            fin_now = 0;
            if (phase == 0) begin
                if (v && rdy) begin
                    chk("sb_has_txn", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        et = sb[0].t; em = sb[0].m; phase = 1; cnt = 0;
                    end
                end
            end else if (phase == 1) begin
                if (en) begin
                    cnt++;
                    if (em == 2'b10 && eq != et) eq = eq + 4'd1;
                    else begin
                        eq = et; phase = 2; fin_now = 1;
                    end
                end
            end else phase = 0;
            chk("done", done, phase == 2);
            if (fin_now) begin
                chk("latency", cnt, sb[0].lat);
                chk("q_at_done", Q, sb[0].t);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;
        send(4'b1010, 2'b00, 0, -10, -10);
        send(4'b0110, 2'b00, 0, -10, -10);
        send(4'b1001, 2'b01, 0, -10, -10);
        send(4'b1110, 2'b00, 0, -10, -10);
        send(4'b0001, 2'b10, 0, -10, -10);
        send(4'b0000, 2'b00, 0, -10, -10);
        send(4'b0011, 2'b10, 0, 1, -10);
        send(4'b0000, 2'b00, 0, -10, -10);
        send(4'b1111, 2'b10, 0, -10, 2);
        send(4'b0101, 2'b11, 0, -10, -10);
        send(4'b0101, 2'b00, 0, -10, -10);
        send(4'b0101, 2'b01, 0, -10, -10);
        send(4'b0101, 2'b10, 0, -10, -10);
        send(4'b0100, 2'b10, 0, -10, -10);
        for (int n = 0; n < 60; n++)
            send(4'($urandom), 2'($urandom), 1, -10,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -10);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
